// File: rtl/lfsr_gen.sv
// Fibonacci LFSR PRBS generator: seed load, shift enable, wrap pulse, all-zero detect.
// Optional build macro LFSR_LOCKUP_RECOVER_EN: a step from the all-zero state reloads SEED.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             y,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             wrap_q, wrap_d;
  logic             feedback;
  logic             is_zero;

  always_comb begin
    is_zero  = (state_q == '0);
    feedback = ^(state_q & TAPS);
    state_d  = state_q;
    ref_d    = ref_q;
    wrap_d   = 1'b0;
    if (load) begin
      state_d = seed;
      ref_d   = seed;
    end else if (en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (is_zero) begin
        state_d = SEED;
        ref_d   = SEED;
      end else begin
        state_d = {feedback, state_q[WIDTH-1:1]};
        wrap_d  = (state_d == ref_q);
      end
`else
      // a stuck zero register shifts to zero again; it must not count as a wrap
      state_d = {feedback, state_q[WIDTH-1:1]};
      wrap_d  = !is_zero && (state_d == ref_q);
`endif
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= SEED;
      ref_q   <= SEED;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state  = state_q;
  assign y      = state_q[0];
  assign wrap   = wrap_q;
  assign lockup = is_zero;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: scoreboard of expected state/y/wrap/lockup per clock, plus a WIDTH=3 instance.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0, load = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       y, wrap, lockup;
  logic [3:0] state;

  logic       en3 = 1'b0, load3 = 1'b0;
  logic [2:0] seed3 = 3'h0;
  logic       y3, wrap3, lockup3;
  logic [2:0] state3;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       w;
    logic       lk;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_state, m_ref;
  logic [3:0] seq_tab[16];
  logic [2:0] seq3_tab[8];

  lfsr_gen u_dut (
    .clk(clk), .res(res), .en(en), .load(load), .seed(seed),
    .y(y), .state(state), .wrap(wrap), .lockup(lockup)
  );

  lfsr_gen #(.WIDTH(3), .TAPS(3'b011), .SEED(3'b111)) u_dut3 (
    .clk(clk), .res(res), .en(en3), .load(load3), .seed(seed3),
    .y(y3), .state(state3), .wrap(wrap3), .lockup(lockup3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // independent reference: x^4+x^3+1 taps, bit3 <= s3^s0
  task automatic cyc(input logic e, input logic l, input logic [3:0] sd);
    logic [3:0] nxt, nref;
    logic       w;
    exp_t       x;
    @(negedge clk);
    en = e; load = l; seed = sd;
    nxt = m_state; nref = m_ref; w = 1'b0;
    if (l) begin
      nxt = sd; nref = sd;
    end else if (e) begin
      if (m_state == 4'h0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        nxt = 4'hF; nref = 4'hF;
`else
        nxt = 4'h0;
`endif
      end else begin
        nxt = {m_state[3] ^ m_state[0], m_state[3:1]};
        w   = (nxt == m_ref);
      end
    end
    m_state = nxt; m_ref = nref;
    sb.push_back('{st: nxt, w: w, lk: (nxt == 4'h0)});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("state", state, x.st);
    check("y", y, x.st[0]);
    check("wrap", wrap, x.w);
    check("lockup", lockup, x.lk);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    #2 res = 1'b0;
    #1;
    check({tag, "_state"}, state, 4'hF);
    check({tag, "_wrap"}, wrap, 1'b0);
    check({tag, "_y"}, y, 1'b1);
    check({tag, "_lockup"}, lockup, 1'b0);
    @(negedge clk);
    res = 1'b1;
    m_state = 4'hF; m_ref = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_cnt, wrap_at;
    seq_tab  = '{4'hF, 4'h7, 4'hB, 4'h5, 4'hA, 4'hD, 4'h6, 4'h3,
                 4'h9, 4'h4, 4'h2, 4'h1, 4'h8, 4'hC, 4'hE, 4'hF};
    seq3_tab = '{3'h7, 3'h3, 3'h1, 3'h4, 3'h2, 3'h5, 3'h6, 3'h7};
    m_state = 4'hF; m_ref = 4'hF;

    #17 res = 1'b1;
    #1;
    check("rst_state", state, 4'hF);
    check("rst_y", y, 1'b1);
    check("rst_wrap", wrap, 1'b0);
    check("rst_lockup", lockup, 1'b0);

    // first period against the literal sequence
    wrap_cnt = 0; wrap_at = -1;
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      check("seq_state", state, seq_tab[i]);
      check("seq_y", y, seq_tab[i][0]);
      if (wrap) begin wrap_cnt++; wrap_at = i; end
    end
    check("wrap_count_p1", wrap_cnt, 1);
    check("wrap_at_p1", wrap_at, 15);
    wrap_cnt = 0; wrap_at = -1;
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap) begin wrap_cnt++; wrap_at = i; end
    end
    check("wrap_count_p2", wrap_cnt, 1);
    check("wrap_at_p2", wrap_at, 15);
    check("wrap_high_before_rst", wrap, 1'b1);
    async_reset("rst_on_wrap");

    // hold at 0101, then resume
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h0);
    check("pre_hold", state, 4'h5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0);
    check("hold_state", state, 4'h5);
    cyc(1'b1, 1'b0, 4'h0);
    check("resume", state, 4'hA);
    cyc(1'b1, 1'b0, 4'h0);
    check("pre_load", state, 4'hD);

    // load beats en; wrap reference follows the load
    cyc(1'b1, 1'b1, 4'h3);
    check("load_wins", state, 4'h3);
    check("load_no_wrap", wrap, 1'b0);
    wrap_cnt = 0; wrap_at = -1;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap) begin wrap_cnt++; wrap_at = i; end
    end
    check("load_wrap_count", wrap_cnt, 1);
    check("load_wrap_at", wrap_at, 15);
    check("load_wrap_state", state, 4'h3);
    cyc(1'b1, 1'b1, 4'h3);
    check("reload_same_no_wrap", wrap, 1'b0);

    // async reset at 1001 restores state and reference
    async_reset("rst_clr");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 4'h0);
    check("at_1001", state, 4'h9);
    async_reset("rst_1001");
    wrap_cnt = 0; wrap_at = -1;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap) begin wrap_cnt++; wrap_at = i; end
    end
    check("ref_restored_at", wrap_at, 15);

    // all-zero lockup
    cyc(1'b0, 1'b1, 4'h0);
    check("zero_lockup", lockup, 1'b1);
    wrap_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (wrap) wrap_cnt++;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (i == 0) check("recover_first", state, 4'hF);
      if (i == 1) check("recover_second", state, 4'h7);
`endif
    end
    check("zero_wrap_count", wrap_cnt, 0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("zero_final_state", state, 4'h5);
    check("zero_final_lockup", lockup, 1'b0);
`else
    check("zero_final_state", state, 4'h0);
    check("zero_final_lockup", lockup, 1'b1);
`endif
    check("sb_empty", sb.size(), 0);

    // WIDTH=3 instance, two periods
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    check("w3_init", state3, 3'h7);
    en3 = 1'b1;
    wrap_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      check("w3_state", state3, seq3_tab[(i - 1) % 7 + 1]);
      check("w3_wrap", wrap3, (i % 7) == 0);
      if (wrap3) wrap_cnt++;
    end
    check("w3_wrap_count", wrap_cnt, 2);
    en3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
